// File: rtl/cmd_frame_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cmd_frame_ctrl : UART command-frame decoder driving register file and ALU  |
// | Optional inter-byte timeout enabled by macro CMD_FRAME_TIMEOUT_EN          |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module cmd_frame_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int OUT_WIDTH  = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    input  logic [OUT_WIDTH-1:0]  ALU_OUT,
    input  logic                  OUT_Valid,
    input  logic [DATA_WIDTH-1:0] RdData,
    input  logic                  RdData_Valid,
    input  logic                  fifo_full,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_D_VLD,
    output logic [ADDR_WIDTH-1:0] Address,
    output logic                  WrEn,
    output logic                  RdEn,
    output logic [DATA_WIDTH-1:0] WrData,
    output logic [3:0]            ALU_FUN,
    output logic                  EN,
    output logic                  CLK_EN,
    output logic                  clk_div_en,
    output logic                  frame_err
);

    localparam int c_NBYTES = OUT_WIDTH / DATA_WIDTH;
    localparam int c_CNT_W  = $clog2(c_NBYTES + 1);

    localparam logic [DATA_WIDTH-1:0] c_CMD_WR  = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] c_CMD_RD  = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] c_CMD_ALU = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] c_CMD_FUN = DATA_WIDTH'(8'hDD);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_WR_ADDR  = 4'd1,
        S_WR_DATA  = 4'd2,
        S_RD_ADDR  = 4'd3,
        S_RD_WAIT  = 4'd4,
        S_OP_A     = 4'd5,
        S_OP_B     = 4'd6,
        S_OP_FUN   = 4'd7,
        S_ALU_WAIT = 4'd8,
        S_TX_SEND  = 4'd9
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [OUT_WIDTH-1:0]   r_tx_buf, w_tx_buf_nxt;
    logic [c_CNT_W-1:0]     r_tx_rem, w_tx_rem_nxt;
    logic [DATA_WIDTH-1:0]  w_txdata_nxt, w_wrdata_nxt;
    logic [ADDR_WIDTH-1:0]  w_addr_nxt;
    logic [3:0]             w_alufun_nxt;
    logic                   w_txvld_nxt, w_wren_nxt, w_rden_nxt;
    logic                   w_en_nxt, w_clken_nxt, w_ferr_nxt;
    logic                   w_timeout;

`ifdef CMD_FRAME_TIMEOUT_EN
    localparam logic [15:0] c_TO_LAST = 16'(TIMEOUT - 1);

    logic [15:0] r_to_cnt;
    logic        w_rx_state;

    assign w_rx_state = (r_state inside {S_WR_ADDR, S_WR_DATA, S_RD_ADDR,
                                         S_OP_A, S_OP_B, S_OP_FUN});
    assign w_timeout  = w_rx_state && !RX_D_VLD && (r_to_cnt == c_TO_LAST);

    // Counter restarts on every accepted byte and on any state change
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_to_cnt <= '0;
        end else if (!w_rx_state || RX_D_VLD || (w_state_nxt != r_state)) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 16'd1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_tx_buf_nxt = r_tx_buf;
        w_tx_rem_nxt = r_tx_rem;
        w_txdata_nxt = TX_P_DATA;
        w_wrdata_nxt = WrData;
        w_addr_nxt   = Address;
        w_alufun_nxt = ALU_FUN;
        w_clken_nxt  = CLK_EN;
        w_txvld_nxt  = 1'b0;
        w_wren_nxt   = 1'b0;
        w_rden_nxt   = 1'b0;
        w_en_nxt     = 1'b0;
        w_ferr_nxt   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (RX_D_VLD) begin
                    case (RX_P_DATA)
                        c_CMD_WR:  w_state_nxt = S_WR_ADDR;
                        c_CMD_RD:  w_state_nxt = S_RD_ADDR;
                        c_CMD_ALU: w_state_nxt = S_OP_A;
                        c_CMD_FUN: w_state_nxt = S_OP_FUN;
                        default:   w_ferr_nxt  = 1'b1;
                    endcase
                end
            end
            S_WR_ADDR: begin
                if (RX_D_VLD) begin
                    w_addr_nxt  = RX_P_DATA[ADDR_WIDTH-1:0];
                    w_state_nxt = S_WR_DATA;
                end
            end
            S_WR_DATA: begin
                if (RX_D_VLD) begin
                    w_wrdata_nxt = RX_P_DATA;
                    w_wren_nxt   = 1'b1;
                    w_state_nxt  = S_IDLE;
                end
            end
            S_RD_ADDR: begin
                if (RX_D_VLD) begin
                    w_addr_nxt  = RX_P_DATA[ADDR_WIDTH-1:0];
                    w_rden_nxt  = 1'b1;
                    w_state_nxt = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (RdData_Valid) begin
                    w_tx_buf_nxt = OUT_WIDTH'(RdData);
                    w_tx_rem_nxt = c_CNT_W'(1);
                    w_state_nxt  = S_TX_SEND;
                end
            end
            S_OP_A: begin
                if (RX_D_VLD) begin
                    w_addr_nxt   = '0;
                    w_wrdata_nxt = RX_P_DATA;
                    w_wren_nxt   = 1'b1;
                    w_state_nxt  = S_OP_B;
                end
            end
            S_OP_B: begin
                if (RX_D_VLD) begin
                    w_addr_nxt   = ADDR_WIDTH'(1);
                    w_wrdata_nxt = RX_P_DATA;
                    w_wren_nxt   = 1'b1;
                    w_state_nxt  = S_OP_FUN;
                end
            end
            S_OP_FUN: begin
                if (RX_D_VLD) begin
                    w_alufun_nxt = RX_P_DATA[3:0];
                    w_en_nxt     = 1'b1;
                    w_clken_nxt  = 1'b1;
                    w_state_nxt  = S_ALU_WAIT;
                end
            end
            S_ALU_WAIT: begin
                // ALU clock stays gated on through the result cycle
                if (OUT_Valid) begin
                    w_clken_nxt  = 1'b0;
                    w_tx_buf_nxt = ALU_OUT;
                    w_tx_rem_nxt = c_CNT_W'(c_NBYTES);
                    w_state_nxt  = S_TX_SEND;
                end
            end
            S_TX_SEND: begin
                // Buffer shifts down so the next byte is always in the low lane
                if (!fifo_full) begin
                    w_txdata_nxt = r_tx_buf[DATA_WIDTH-1:0];
                    w_txvld_nxt  = 1'b1;
                    w_tx_buf_nxt = r_tx_buf >> DATA_WIDTH;
                    w_tx_rem_nxt = r_tx_rem - 1'b1;
                    if (r_tx_rem == c_CNT_W'(1)) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_timeout) begin
            w_state_nxt = S_IDLE;
            w_ferr_nxt  = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= S_IDLE;
            r_tx_buf   <= '0;
            r_tx_rem   <= '0;
            TX_P_DATA  <= '0;
            TX_D_VLD   <= 1'b0;
            Address    <= '0;
            WrEn       <= 1'b0;
            RdEn       <= 1'b0;
            WrData     <= '0;
            ALU_FUN    <= '0;
            EN         <= 1'b0;
            CLK_EN     <= 1'b0;
            clk_div_en <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_tx_buf   <= w_tx_buf_nxt;
            r_tx_rem   <= w_tx_rem_nxt;
            TX_P_DATA  <= w_txdata_nxt;
            TX_D_VLD   <= w_txvld_nxt;
            Address    <= w_addr_nxt;
            WrEn       <= w_wren_nxt;
            RdEn       <= w_rden_nxt;
            WrData     <= w_wrdata_nxt;
            ALU_FUN    <= w_alufun_nxt;
            EN         <= w_en_nxt;
            CLK_EN     <= w_clken_nxt;
            clk_div_en <= 1'b1;
            frame_err  <= w_ferr_nxt;
        end
    end

endmodule
`default_nettype wire

// File: doc/cmd_frame_ctrl.md
CMD_FRAME_CTRL -- requirements
Module: cmd_frame_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8, frame byte / register data width.
REQ-002 Parameter ADDR_WIDTH, default 4, register file address width.
REQ-003 Parameter OUT_WIDTH, default 16, ALU result width; SHALL be an integer multiple of DATA_WIDTH.
REQ-004 Parameter TIMEOUT, default 255, inter-byte timeout in CLK cycles; legal range 1..65535.
REQ-005 CLK  in  1  single clock; all logic rising-edge.
REQ-006 RST  in  1  reset, asynchronous, active-low.
REQ-007 RX_P_DATA  in  DATA_WIDTH  received byte; RX_D_VLD  in  1  one-cycle strobe qualifying RX_P_DATA.
REQ-008 ALU_OUT  in  OUT_WIDTH  ALU result; OUT_Valid  in  1  ALU result strobe.
REQ-009 RdData  in  DATA_WIDTH  register read data; RdData_Valid  in  1  read data strobe.
REQ-010 fifo_full  in  1  TX FIFO full; TX_P_DATA  out  DATA_WIDTH  byte to FIFO; TX_D_VLD  out  1  FIFO write strobe.
REQ-011 Address  out  ADDR_WIDTH; WrEn  out  1; RdEn  out  1; WrData  out  DATA_WIDTH  register file port.
REQ-012 ALU_FUN  out  4; EN  out  1  ALU start; CLK_EN  out  1  ALU clock-gate enable.
REQ-013 clk_div_en  out  1  clock divider enable; frame_err  out  1  one-cycle frame error pulse.

Function
REQ-014 All outputs SHALL be registered; bytes accepted only in cycles with RX_D_VLD=1.
REQ-015 States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, OP_FUN, ALU_WAIT, TX_SEND.
REQ-016 IDLE command decode: 0xAA->WR_ADDR, 0xBB->RD_ADDR, 0xCC->OP_A, 0xDD->OP_FUN; any other byte SHALL pulse frame_err one cycle and stay IDLE.
REQ-017 Register write: WR_ADDR captures Address=byte[ADDR_WIDTH-1:0]; WR_DATA captures WrData and asserts WrEn exactly one cycle in the next cycle; return to IDLE; no TX byte.
REQ-018 Register read: RD_ADDR captures Address and asserts RdEn one cycle; RD_WAIT holds until RdData_Valid, latches RdData, enters TX_SEND with one byte.
REQ-019 OP_A byte SHALL be written to address 0, OP_B byte to address 1, each via one-cycle WrEn as REQ-017.
REQ-020 OP_FUN captures ALU_FUN=byte[3:0]; next cycle EN pulses one cycle and CLK_EN rises; CLK_EN SHALL stay 1 until the cycle after OUT_Valid.
REQ-021 ALU_WAIT latches ALU_OUT on OUT_Valid and enters TX_SEND with OUT_WIDTH/DATA_WIDTH bytes, least-significant byte first.
REQ-022 TX_SEND: one byte per cycle with TX_D_VLD=1 only when fifo_full=0; fifo_full=1 SHALL stall, holding byte index; return to IDLE after last byte.
REQ-023 RX_D_VLD in RD_WAIT, ALU_WAIT or TX_SEND SHALL be ignored (byte dropped, no frame_err).
REQ-024 clk_div_en SHALL be 0 in reset and 1 from the first clock after reset release.

Reset
REQ-025 RST low SHALL immediately force IDLE and all outputs to 0, including mid-frame and mid-TX_SEND; the partial frame SHALL be discarded.
REQ-026 After release, first RX byte SHALL be decoded as a command.

Configuration
REQ-027 Macro CMD_FRAME_TIMEOUT_EN defined: in WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B, OP_FUN a 16-bit counter SHALL clear on each accepted byte and on state entry; reaching TIMEOUT SHALL force IDLE and pulse frame_err one cycle.
REQ-028 Macro CMD_FRAME_TIMEOUT_EN undefined: no counter instantiated; receive states wait indefinitely; frame_err driven only by REQ-016.

Verification
REQ-029 Bytes 0xAA,0x05,0x3C -> Address=5, WrData=0x3C, WrEn one cycle, no TX_D_VLD.
REQ-030 Bytes 0xBB,0x02, RdData=0x7E with RdData_Valid -> RdEn one cycle, single TX_D_VLD with TX_P_DATA=0x7E.
REQ-031 Bytes 0xCC,0x03,0x04,0x00, ALU_OUT=0x0007 with OUT_Valid -> writes addr0=3, addr1=4, EN one cycle, TX bytes 0x07 then 0x00.
REQ-032 0xDD,0x02, ALU_OUT=0x1234, fifo_full=1 for 5 cycles -> no TX_D_VLD while full, then 0x34, 0x12.
REQ-033 Byte 0x55 in IDLE -> frame_err one cycle, state IDLE; then 0xAA frame works normally.
REQ-034 With CMD_FRAME_TIMEOUT_EN, TIMEOUT=10: 0xAA then silence -> frame_err at cycle 10, IDLE; RST low mid-frame -> all outputs 0 asynchronously.
